// File: rtl/ms_alarm_sched.sv
// Multi-channel millisecond alarm scheduler: one-shot/periodic countdowns clocked by RTC ms ticks,
// with expiries serialised onto a single valid/ack event port by round-robin arbitration.
module ms_alarm_sched #(
    parameter int NCH = 4,
    parameter int CW  = 2,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic [31:0]   ms_acc,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic          cfg_arm,
    input  logic          cfg_periodic,
    input  logic [DW-1:0] cfg_delay,
    output logic          evt_valid,
    output logic [CW-1:0] evt_ch,
    input  logic          evt_ack,
    output logic [NCH-1:0] armed,
    output logic [NCH-1:0] overrun
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } evt_state_t;

    logic [31:0]    ms_acc_q;
    logic           init_done;
    logic           tick;
    logic           cfg_fire;
    logic [DW-1:0]  delay_eff;

    logic [DW-1:0]  rem    [NCH];
    logic [DW-1:0]  reload [NCH];
    logic [NCH-1:0] periodic;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] ack_clr;

    evt_state_t     state_q, state_d;
    logic [CW-1:0]  ch_q, ch_d;
    logic [CW-1:0]  rr_q, rr_d;
    logic [CW-1:0]  grant;
    logic           grant_vld;
    logic           ack_fire;
    logic [CW:0]    rr_sum;
    logic [CW-1:0]  rr_idx;

    // Any change of ms_acc is a tick, including the 2^32 wrap; the first cycle out of reset only samples.
    assign tick      = init_done & (ms_acc != ms_acc_q);
    assign cfg_ready = init_done & ~tick;
    assign cfg_fire  = cfg_valid & cfg_ready;
    assign delay_eff = (cfg_delay == '0) ? DW'(1) : cfg_delay;

    assign evt_valid = (state_q == S_PRESENT);
    assign evt_ch    = ch_q;
    assign ack_fire  = evt_valid & evt_ack;

    always_comb begin
        expire  = '0;
        ack_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            expire[i]  = tick & armed[i] & (rem[i] == DW'(1));
            ack_clr[i] = ack_fire & (ch_q == CW'(i));
        end
    end

    // Round-robin search: first pending channel at or after rr_q, wrapping past NCH-1.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_sum = {1'b0, rr_q} + (CW+1)'(k);
            if (rr_sum >= (CW+1)'(NCH)) begin
                rr_sum = rr_sum - (CW+1)'(NCH);
            end
            rr_idx = rr_sum[CW-1:0];
            if (!grant_vld && pending[rr_idx]) begin
                grant_vld = 1'b1;
                grant     = rr_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    state_d = S_PRESENT;
                    ch_d    = grant;
                end
            end
            S_PRESENT: begin
                if (evt_ack) begin
                    state_d = S_IDLE;
                    rr_d    = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            ms_acc_q  <= '0;
            init_done <= 1'b0;
            state_q   <= S_IDLE;
            ch_q      <= '0;
            rr_q      <= '0;
            periodic  <= '0;
            pending   <= '0;
            armed     <= '0;
            overrun   <= '0;
            for (int i = 0; i < NCH; i++) begin
                rem[i]    <= '0;
                reload[i] <= '0;
            end
        end else begin
            ms_acc_q  <= ms_acc;
            init_done <= 1'b1;
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_q      <= rr_d;
            // Commands only land in non-tick cycles, so cfg_fire and expire never coincide.
            for (int i = 0; i < NCH; i++) begin
                if (cfg_fire && (cfg_ch == CW'(i))) begin
                    if (cfg_arm) begin
                        rem[i]      <= delay_eff;
                        reload[i]   <= delay_eff;
                        periodic[i] <= cfg_periodic;
                        armed[i]    <= 1'b1;
                        if (ack_clr[i]) begin
                            pending[i] <= 1'b0;
                        end
                    end else begin
                        armed[i]   <= 1'b0;
                        pending[i] <= 1'b0;
                        overrun[i] <= 1'b0;
                    end
                end else if (expire[i]) begin
                    // An ack in the same cycle consumes the old event, so the new one is not an overrun.
                    pending[i] <= 1'b1;
                    overrun[i] <= overrun[i] | (pending[i] & ~ack_clr[i]);
                    if (periodic[i]) begin
                        rem[i] <= reload[i];
                    end else begin
                        armed[i] <= 1'b0;
                    end
                end else begin
                    if (tick && armed[i]) begin
                        rem[i] <= rem[i] - DW'(1);
                    end
                    if (ack_clr[i]) begin
                        pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ms_alarm_sched.sv
// Bench for ms_alarm_sched: directed scenarios plus random traffic, checked by a scoreboard fed
// from a behavioural model of the channel/event rules.
module tb_ms_alarm_sched;

    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           rstb;
    logic [31:0]    ms_acc;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CW-1:0]  cfg_ch;
    logic           cfg_arm;
    logic           cfg_periodic;
    logic [DW-1:0]  cfg_delay;
    logic           evt_valid;
    logic [CW-1:0]  evt_ch;
    logic           evt_ack;
    logic [NCH-1:0] armed;
    logic [NCH-1:0] overrun;

    ms_alarm_sched #(.NCH(NCH), .CW(CW), .DW(DW)) dut (
        .clk(clk), .rstb(rstb), .ms_acc(ms_acc),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_arm(cfg_arm), .cfg_periodic(cfg_periodic), .cfg_delay(cfg_delay),
        .evt_valid(evt_valid), .evt_ch(evt_ch), .evt_ack(evt_ack),
        .armed(armed), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Stimulus state for the next cycle
    bit          s_rstb  = 1'b0;
    logic [31:0] s_acc   = 32'd500;
    bit          s_cv    = 1'b0;
    int          s_ch    = 0;
    bit          s_arm   = 1'b0;
    bit          s_per   = 1'b0;
    int          s_delay = 0;
    int          ack_mode = 1;   // 0 never, 1 always, 2 random
    bit          last_acc;
    int          last_cfg_cycles;

    // Behavioural model: ms remaining per channel, plus what the event port is showing.
    int             m_left   [NCH];
    int             m_period [NCH];
    bit [NCH-1:0]   m_per    = '0;
    bit [NCH-1:0]   m_pend   = '0;
    bit [NCH-1:0]   m_armed  = '0;
    bit [NCH-1:0]   m_ovr    = '0;
    bit             m_init   = 1'b0;
    logic [31:0]    m_last_ms = '0;
    bit             m_showing = 1'b0;
    int             m_ch     = 0;
    int             m_next   = 0;

    typedef struct {
        int ch;
        int edge_n;
    } exp_t;
    exp_t exp_q[$];
    int   seen[$];

    task automatic model_reset();
        m_per = '0; m_pend = '0; m_armed = '0; m_ovr = '0;
        m_init = 1'b0; m_last_ms = '0; m_showing = 1'b0; m_ch = 0; m_next = 0;
        for (int i = 0; i < NCH; i++) begin
            m_left[i] = 0;
            m_period[i] = 0;
        end
    endtask

    // Advance the model across the coming clock edge, given the inputs now being driven.
    task automatic model_step(output bit accepted);
        bit new_ms, can_cfg, took_ack, consumed;
        bit n_showing;
        int n_ch, n_next;
        accepted = 1'b0;
        if (!s_rstb) begin
            model_reset();
            return;
        end
        new_ms   = m_init && (s_acc != m_last_ms);
        can_cfg  = m_init && !new_ms;
        took_ack = m_showing && evt_ack;
        n_showing = m_showing;
        n_ch = m_ch;
        n_next = m_next;
        if (m_showing) begin
            if (evt_ack) begin
                n_showing = 1'b0;
                n_next = (m_ch + 1) % NCH;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_next + k) % NCH;
                if (m_pend[c]) begin
                    n_showing = 1'b1;
                    n_ch = c;
                    exp_q.push_back('{ch: c, edge_n: cyc + 1});
                    break;
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            consumed = took_ack && (m_ch == i);
            if (can_cfg && s_cv && s_ch == i) begin
                accepted = 1'b1;
                if (s_arm) begin
                    m_left[i]   = (s_delay == 0) ? 1 : s_delay;
                    m_period[i] = m_left[i];
                    m_per[i]    = s_per;
                    m_armed[i]  = 1'b1;
                    if (consumed) m_pend[i] = 1'b0;
                end else begin
                    m_armed[i] = 1'b0;
                    m_pend[i]  = 1'b0;
                    m_ovr[i]   = 1'b0;
                end
            end else if (new_ms && m_armed[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    if (m_pend[i] && !consumed) m_ovr[i] = 1'b1;
                    m_pend[i] = 1'b1;
                    if (m_per[i]) m_left[i] = m_period[i];
                    else m_armed[i] = 1'b0;
                end else if (consumed) begin
                    m_pend[i] = 1'b0;
                end
            end else if (consumed) begin
                m_pend[i] = 1'b0;
            end
        end
        m_last_ms = s_acc;
        m_init = 1'b1;
        m_showing = n_showing;
        m_ch = n_ch;
        m_next = n_next;
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compares status each cycle and pops the scoreboard whenever a new event appears.
    bit prev_v = 1'b0;
    int prev_ch = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        check("armed", armed, m_armed);
        check("overrun", overrun, m_ovr);
        while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
            e = exp_q.pop_front();
            check("evt_missing_ch", -1, e.ch);
        end
        if (evt_valid && !prev_v) begin
            seen.push_back(int'(evt_ch));
            if (exp_q.size() == 0) begin
                check("evt_unexpected_ch", evt_ch, -1);
            end else begin
                e = exp_q.pop_front();
                check("evt_ch", evt_ch, e.ch);
                check("evt_cycle", cyc, e.edge_n);
            end
        end else if (evt_valid && prev_v) begin
            check("evt_ch_stable", evt_ch, prev_ch);
        end
        prev_v = evt_valid;
        prev_ch = int'(evt_ch);
    end

    task automatic cycle();
        bit ok;
        bit exp_ready;
        @(negedge clk);
        rstb = s_rstb;
        ms_acc = s_acc;
        cfg_valid = s_cv;
        cfg_ch = CW'(s_ch);
        cfg_arm = s_arm;
        cfg_periodic = s_per;
        cfg_delay = DW'(s_delay);
        case (ack_mode)
            0: evt_ack = 1'b0;
            1: evt_ack = 1'b1;
            default: evt_ack = 1'($urandom_range(0, 1));
        endcase
        exp_ready = m_init && (s_acc == m_last_ms);
        #1;
        check("cfg_ready", cfg_ready, exp_ready);
        model_step(ok);
        last_acc = ok;
        @(posedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic tick_ms(int gap);
        s_acc = s_acc + 32'd1;
        cycle();
        idle(gap);
    endtask

    task automatic do_cfg(int ch, bit arm, bit per, int dly);
        bit ok;
        ok = 1'b0;
        last_cfg_cycles = 0;
        s_cv = 1'b1; s_ch = ch; s_arm = arm; s_per = per; s_delay = dly;
        for (int i = 0; i < 8 && !ok; i++) begin
            cycle();
            last_cfg_cycles++;
            ok = last_acc;
        end
        s_cv = 1'b0;
        check("cfg_accepted", ok, 1);
    endtask

    task automatic do_reset(int n);
        s_rstb = 1'b0;
        idle(n);
        s_rstb = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_left[i] = 0;
            m_period[i] = 0;
        end
        rstb = 1'b0; ms_acc = 32'd500; cfg_valid = 1'b0; cfg_ch = '0;
        cfg_arm = 1'b0; cfg_periodic = 1'b0; cfg_delay = '0; evt_ack = 1'b0;

        // Reset with ms_acc=500, then release: one cycle of cfg_ready low, no tick.
        s_acc = 32'd500;
        do_reset(3);
        #2;
        check("rst_evt_valid", evt_valid, 0);
        check("rst_armed", armed, 0);
        check("rst_overrun", overrun, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        cycle();
        #2;
        check("post_rst_cfg_ready", cfg_ready, 1);
        check("post_rst_evt_valid", evt_valid, 0);

        // One-shot ch1, delay 3
        ack_mode = 1;
        do_cfg(1, 1'b1, 1'b0, 3);
        tick_ms(1); tick_ms(1); tick_ms(0);
        idle(4);
        #2;
        check("oneshot_disarmed", armed[1], 0);
        check("oneshot_events", seen.size(), 1);

        // Periodic ch0, delay 2, acked every time
        seen.delete();
        do_cfg(0, 1'b1, 1'b1, 2);
        repeat (6) tick_ms(3);
        #2;
        check("periodic_events", seen.size(), 3);
        check("periodic_overrun", overrun[0], 0);
        do_cfg(0, 1'b0, 1'b0, 0);

        // Round-robin from a fresh pointer
        do_reset(1);
        idle(1);
        seen.delete();
        for (int c = 0; c < NCH; c++) do_cfg(c, 1'b1, 1'b0, 1);
        tick_ms(12);
        check("rr_count", seen.size(), NCH);
        for (int c = 0; c < NCH && c < seen.size(); c++) check("rr_order", seen[c], c);

        // Overrun on ch2 while its event is held
        ack_mode = 0;
        seen.delete();
        do_cfg(2, 1'b1, 1'b1, 1);
        repeat (3) tick_ms(2);
        #2;
        check("ovr_set", overrun[2], 1);
        check("ovr_single_event", seen.size(), 1);
        do_cfg(2, 1'b0, 1'b0, 0);
        #2;
        check("ovr_cleared", overrun[2], 0);
        check("disarm_keeps_evt", evt_valid, 1);
        ack_mode = 1;
        idle(3);
        #2;
        check("held_evt_acked", evt_valid, 0);

        // Wrap of ms_acc with a command held across the tick
        s_acc = 32'hFFFF_FFFE;
        idle(2);
        s_acc = 32'hFFFF_FFFF;
        idle(2);
        do_cfg(3, 1'b1, 1'b0, 1);
        seen.delete();
        s_acc = 32'h0000_0000;
        do_cfg(0, 1'b1, 1'b0, 5);
        check("wrap_cfg_wait", last_cfg_cycles, 2);
        idle(4);
        check("wrap_events", seen.size(), 1);
        if (seen.size() > 0) check("wrap_ch", seen[0], 3);

        // Random traffic, including a wrap and occasional resets
        ack_mode = 2;
        s_acc = 32'hFFFF_FFF0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10) begin
                do_cfg($urandom_range(0, NCH - 1), ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)), $urandom_range(0, 6));
            end else if (r < 45) begin
                tick_ms(0);
            end else if (r < 46) begin
                do_reset(1);
            end else begin
                cycle();
            end
        end

        ack_mode = 1;
        for (int c = 0; c < NCH; c++) do_cfg(c, 1'b0, 1'b0, 0);
        idle(20);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
